k580vt57: RTL and testbench

Four-channel DMA controller compatible with the K580VT57 (8257). It is the service side of the character-fetch DMA used by the CRT controller: it answers `drq` with `dack`, drives memory addresses and read strobes, and counts transfers to terminal count. It sits between the CPU bus, the RAM arbiter and up to four peripheral requesters, with channel 2 feeding the CRT controller.

---
 rtl/k580vt57.sv | 172 +++++++++++++++++
 tb/tb_k580vt57.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/k580vt57.sv
// k580vt57: four-channel 8257-compatible DMA controller (service side of the CRT fetch DMA).
// Define K580VT57_AUTOLOAD_EN to let mode bit 7 reload channel 2 from channel 3 on terminal count.
module k580vt57 #(
    parameter int XFER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iaddr,
    input  logic [7:0]  idata,
    output logic [7:0]  odata,
    input  logic        iwe_n,
    input  logic        ird_n,
    input  logic [3:0]  drq,
    output logic [3:0]  dack,
    output logic        hrq,
    input  logic        hlda,
    output logic [15:0] oaddr,
    output logic        memr_n,
    output logic        memw_n,
    output logic        tc
);
    typedef enum logic [2:0] {IDLE, HOLD, SEL, XFER, UPD} state_t;

    state_t      state, state_nxt;
    logic [15:0] regs [8];
    logic [7:0]  mode;
    logic        ff;
    logic        update;
    logic [3:0]  tc_flag;
    logic        iwe_d, ird_d;
    logic [1:0]  ch, ch_nxt;
    logic        ch_load;
    logic [7:0]  xcnt;
    logic        wr_stb, rd_stb, active, tc_now;
    logic [15:0] cur_addr, cur_cnt;
    logic [1:0]  xtype;
    logic [3:0]  req, en_upd;
    logic        unused_mode;

    // Lowest offset from the start point wins; rotating starts just after the last serviced channel.
    function automatic logic [1:0] arbitrate(input logic [3:0] r, input logic rot,
                                             input logic [1:0] last);
        logic [1:0] start;
        logic [1:0] idx;
        arbitrate = 2'd0;
        start = rot ? last + 2'd1 : 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) arbitrate = idx;
        end
    endfunction

    assign wr_stb   = iwe_n & ~iwe_d;
    assign rd_stb   = ird_n & ~ird_d;
    assign cur_addr = regs[{ch, 1'b0}];
    assign cur_cnt  = regs[{ch, 1'b1}];
    assign xtype    = cur_cnt[15:14];
    assign tc_now   = (cur_cnt[13:0] == 14'd0);
    assign active   = (state == SEL) || (state == XFER);
    assign req      = drq & mode[3:0];

    assign hrq    = (state != IDLE);
    assign dack   = active ? (4'b0001 << ch) : 4'b0000;
    assign oaddr  = active ? cur_addr : 16'd0;
    assign tc     = active & tc_now;
    assign memr_n = ~((state == XFER) && (xtype == 2'b10));
    assign memw_n = ~((state == XFER) && (xtype == 2'b01));

    // Extended write (bit 5) has no effect; bit 7 only matters with autoload built in.
    assign unused_mode = &{1'b0, mode[7], mode[5]};

    always_comb begin
        en_upd = mode[3:0];
        if (tc_now && mode[6]) en_upd[ch] = 1'b0;
    end

    always_comb begin
        odata = 8'd0;
        if (!iaddr[3]) odata = ff ? regs[iaddr[2:0]][15:8] : regs[iaddr[2:0]][7:0];
        else if (iaddr == 4'd8) odata = {3'b000, update, tc_flag};
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        ch_load   = 1'b0;
        case (state)
            IDLE: if (|req) state_nxt = HOLD;
            HOLD: begin
                if (~|req) begin
                    state_nxt = IDLE;
                end else if (hlda) begin
                    state_nxt = SEL;
                    ch_load   = 1'b1;
                    ch_nxt    = arbitrate(req, mode[4], ch);
                end
            end
            SEL:  state_nxt = XFER;
            XFER: if (xcnt == 8'(XFER_CYCLES - 3)) state_nxt = UPD;
            UPD: begin
                if (hlda && |(drq & en_upd)) begin
                    state_nxt = SEL;
                    ch_load   = 1'b1;
                    ch_nxt    = arbitrate(drq & en_upd, mode[4], ch);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ch    <= 2'd3;
            xcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (ch_load) ch <= ch_nxt;
            xcnt <= (state == XFER) ? xcnt + 8'd1 : 8'd0;
        end
    end

    // CPU accesses are applied after the transfer update so a same-clock write wins its byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
            mode    <= 8'd0;
            ff      <= 1'b0;
            update  <= 1'b0;
            tc_flag <= 4'd0;
            iwe_d   <= 1'b1;
            ird_d   <= 1'b1;
        end else begin
            iwe_d <= iwe_n;
            ird_d <= ird_n;
            if (state == UPD) begin
                regs[{ch, 1'b0}] <= cur_addr + 16'd1;
                regs[{ch, 1'b1}] <= {cur_cnt[15:14], cur_cnt[13:0] - 14'd1};
                if (tc_now) begin
                    tc_flag[ch] <= 1'b1;
                    if (mode[6]) mode[ch] <= 1'b0;
`ifdef K580VT57_AUTOLOAD_EN
                    if (mode[7] && ch == 2'd2) begin
                        regs[4] <= regs[6];
                        regs[5] <= regs[7];
                        update  <= 1'b1;
                    end
`endif
                end
            end
            if (rd_stb) begin
                if (!iaddr[3]) ff <= ~ff;
                else if (iaddr == 4'd8) begin
                    tc_flag <= 4'd0;
                    update  <= 1'b0;
                end
            end
            if (wr_stb) begin
                if (!iaddr[3]) begin
                    if (ff) regs[iaddr[2:0]][15:8] <= idata;
                    else    regs[iaddr[2:0]][7:0]  <= idata;
                    ff <= ~ff;
                end else if (iaddr == 4'd8) begin
                    mode <= idata;
                    ff   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_k580vt57.sv
// Directed scoreboard bench for k580vt57: register access, transfers, priority, TC-stop, autoload, reset.
module tb_k580vt57;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  iaddr;
    logic [7:0]  idata;
    logic [7:0]  odata;
    logic        iwe_n, ird_n;
    logic [3:0]  drq;
    logic [3:0]  dack;
    logic        hrq, hlda;
    logic [15:0] oaddr;
    logic        memr_n, memw_n, tc;

    always #5 clk = ~clk;

    k580vt57 #(.XFER_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata), .odata(odata),
        .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
        .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .tc(tc)
    );

    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic        tc;
        logic        memr_n;
        logic        memw_n;
        logic [3:0]  drq_after;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        iaddr = a; idata = d; iwe_n = 1'b0;
        @(negedge clk);
        iwe_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] v);
        cpu_wr(a, v[7:0]);
        cpu_wr(a, v[15:8]);
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        iaddr = a; ird_n = 1'b0;
        @(negedge clk);
        d = odata;
        ird_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] d, input logic [15:0] a, input logic t,
                        input logic r, input logic w, input logic [3:0] da);
        exp_t e;
        e.dack = d; e.addr = a; e.tc = t; e.memr_n = r; e.memw_n = w; e.drq_after = da;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        int   t;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            t = 0;
            while (dack == 4'd0 && t < 100) begin @(negedge clk); t++; end
            chk("dack_wait_timeout", 32'(t >= 100), 32'd0);
            if (t >= 100) begin
                sb.delete();
                drq = 4'd0;
                return;
            end
            chk("dack", dack, e.dack);
            chk("oaddr", oaddr, e.addr);
            chk("tc", tc, e.tc);
            drq = e.drq_after;
            @(negedge clk);
            chk("memr_n", memr_n, e.memr_n);
            chk("memw_n", memw_n, e.memw_n);
            t = 0;
            while (dack != 4'd0 && t < 100) begin @(negedge clk); t++; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         seen;
        int         t;
        reset = 1'b1; iaddr = 4'd0; idata = 8'd0; iwe_n = 1'b1; ird_n = 1'b1;
        drq = 4'd0; hlda = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_odata", odata, 8'h00);
        chk("rst_dack", dack, 4'd0);
        chk("rst_hrq", hrq, 1'b0);
        chk("rst_tc", tc, 1'b0);
        chk("rst_oaddr", oaddr, 16'd0);
        chk("rst_memr_n", memr_n, 1'b1);
        chk("rst_memw_n", memw_n, 1'b1);

        // Byte-pointer register access
        cpu_wr(4'd2, 8'h34); cpu_wr(4'd2, 8'h12);
        cpu_wr(4'd3, 8'h05); cpu_wr(4'd3, 8'h80);
        cpu_rd(4'd2, rd); chk("reg_ch1_addr_lo", rd, 8'h34);
        cpu_rd(4'd2, rd); chk("reg_ch1_addr_hi", rd, 8'h12);
        cpu_rd(4'd3, rd); chk("reg_ch1_cnt_lo", rd, 8'h05);
        cpu_rd(4'd3, rd); chk("reg_ch1_cnt_hi", rd, 8'h80);
        cpu_wr(4'd2, 8'h55);
        cpu_wr(4'd8, 8'h00);
        cpu_rd(4'd2, rd); chk("ff_clear_by_mode", rd, 8'h55);
        cpu_wr(4'd8, 8'h00);

        // Rotating then fixed priority, ch0 read / ch2 write
        wr16(4'd0, 16'h2000); wr16(4'd1, 16'h8010);
        wr16(4'd4, 16'h3000); wr16(4'd5, 16'h4010);
        cpu_wr(4'd8, 8'h15);
        hlda = 1'b1;
        push(4'b0001, 16'h2000, 1'b0, 1'b0, 1'b1, 4'b0101);
        push(4'b0100, 16'h3000, 1'b0, 1'b1, 1'b0, 4'b0101);
        push(4'b0001, 16'h2001, 1'b0, 1'b0, 1'b1, 4'b0101);
        push(4'b0100, 16'h3001, 1'b0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk); drq = 4'b0101;
        drain();
        repeat (3) @(negedge clk);
        chk("rot_hrq_released", hrq, 1'b0);
        cpu_wr(4'd8, 8'h05);
        push(4'b0001, 16'h2002, 1'b0, 1'b0, 1'b1, 4'b0101);
        push(4'b0001, 16'h2003, 1'b0, 1'b0, 1'b1, 4'b0101);
        push(4'b0001, 16'h2004, 1'b0, 1'b0, 1'b1, 4'b0100);
        push(4'b0100, 16'h3002, 1'b0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk); drq = 4'b0101;
        drain();
        repeat (3) @(negedge clk);

        // Read burst to terminal count with hrq/hlda handshake
        wr16(4'd0, 16'h1000); wr16(4'd1, 16'h8002);
        cpu_wr(4'd8, 8'h01);
        hlda = 1'b0;
        @(negedge clk); drq = 4'b0001;
        @(negedge clk);
        chk("hrq_after_drq", hrq, 1'b1);
        chk("no_dack_before_hlda", dack, 4'd0);
        hlda = 1'b1;
        push(4'b0001, 16'h1000, 1'b0, 1'b0, 1'b1, 4'b0001);
        push(4'b0001, 16'h1001, 1'b0, 1'b0, 1'b1, 4'b0001);
        push(4'b0001, 16'h1002, 1'b1, 1'b0, 1'b1, 4'b0000);
        drain();
        repeat (3) @(negedge clk);
        chk("read_hrq_released", hrq, 1'b0);
        cpu_rd(4'd8, rd); chk("status_tc0", rd, 8'h01);
        cpu_rd(4'd8, rd); chk("status_cleared", rd, 8'h00);

        // TC-stop on a verify channel
        wr16(4'd2, 16'h5000); wr16(4'd3, 16'h0000);
        cpu_wr(4'd8, 8'h42);
        push(4'b0010, 16'h5000, 1'b1, 1'b1, 1'b1, 4'b0010);
        @(negedge clk); drq = 4'b0010;
        drain();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (dack != 4'd0) seen++;
        end
        chk("tcstop_no_more_dack", seen, 0);
        chk("tcstop_hrq", hrq, 1'b0);
        drq = 4'd0;
        cpu_rd(4'd8, rd); chk("tcstop_status", rd, 8'h02);
        cpu_rd(4'd8, rd); chk("tcstop_status_clr", rd, 8'h00);

        // Channel 2 autoload from channel 3
        wr16(4'd4, 16'h4000); wr16(4'd5, 16'h8001);
        wr16(4'd6, 16'h8000); wr16(4'd7, 16'h8003);
        cpu_wr(4'd8, 8'h84);
        push(4'b0100, 16'h4000, 1'b0, 1'b0, 1'b1, 4'b0100);
        push(4'b0100, 16'h4001, 1'b1, 1'b0, 1'b1, 4'b0100);
`ifdef K580VT57_AUTOLOAD_EN
        push(4'b0100, 16'h8000, 1'b0, 1'b0, 1'b1, 4'b0000);
`else
        push(4'b0100, 16'h4002, 1'b0, 1'b0, 1'b1, 4'b0000);
`endif
        @(negedge clk); drq = 4'b0100;
        drain();
        repeat (3) @(negedge clk);
        cpu_rd(4'd8, rd);
`ifdef K580VT57_AUTOLOAD_EN
        chk("autoload_status", rd, 8'h14);
`else
        chk("autoload_status", rd, 8'h04);
`endif

        // Asynchronous reset in the middle of a read strobe
        wr16(4'd0, 16'h6000); wr16(4'd1, 16'h8005);
        cpu_wr(4'd8, 8'h01);
        @(negedge clk); drq = 4'b0001;
        t = 0;
        while (memr_n !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        chk("memr_wait_timeout", 32'(t >= 100), 32'd0);
        chk("mid_xfer_oaddr", oaddr, 16'h6000);
        #2 reset = 1'b1;
        #1;
        chk("arst_dack", dack, 4'd0);
        chk("arst_hrq", hrq, 1'b0);
        chk("arst_memr_n", memr_n, 1'b1);
        chk("arst_memw_n", memw_n, 1'b1);
        chk("arst_oaddr", oaddr, 16'd0);
        chk("arst_tc", tc, 1'b0);
        @(negedge clk);
        reset = 1'b0; drq = 4'd0; iaddr = 4'd0;
        repeat (2) @(negedge clk);
        chk("arst_regs_cleared", odata, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
